// File: rtl/memory.sv
`default_nettype none
// ============================================================================
//  Module      : memory
//  Description : Byte-organised, little-endian data memory with a single
//                synchronous write port and a combinational read port.
//                Byte, halfword and word accesses may start at any byte
//                address. Addresses past the top of the array wrap to the
//                bottom. Byte and halfword reads are sign- or zero-extended
//                to 32 bits.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_WIDTH  byte-address width; capacity is 2**ADDR_WIDTH bytes
//  Ports
//    clk         clock; every state change happens on its rising edge
//    rst         synchronous active-high reset; clears every byte to 0x00
//    WE          write enable, sampled on the rising edge of clk
//    MemSize     access size: 0 = byte, 1 = halfword, 2/3 = word
//    MemSigned   reads only: 1 = sign-extend, 0 = zero-extend byte/halfword
//    A           byte address of the access (any alignment)
//    WD          write data; byte/halfword writes use the low-order bytes
//    RD          read data, combinational from A, MemSize, MemSigned, array
// ============================================================================
module memory #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WE,
    input  logic [1:0]            MemSize,
    input  logic                  MemSigned,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [31:0]           WD,
    output logic [31:0]           RD
);

    localparam int unsigned c_depth = 2 ** ADDR_WIDTH;

    localparam logic [1:0] c_sizeByte = 2'd0;
    localparam logic [1:0] c_sizeHalf = 2'd1;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [7:0] r_mem [0:c_depth-1];

    // ------------------------------------------------------------------------
    // Per-lane byte addresses and read bytes. Lane k addresses A+k; the
    // addition is carried out at ADDR_WIDTH bits so the carry out of the top
    // bit is dropped, which gives the required modulo-capacity wrap.
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_laneAddr [0:3];
    logic [7:0]            w_laneByte [0:3];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam logic [ADDR_WIDTH-1:0] c_offset = ADDR_WIDTH'(k);
        assign w_laneAddr[k] = A + c_offset;
        assign w_laneByte[k] = r_mem[w_laneAddr[k]];
    end

    // ------------------------------------------------------------------------
    // Lane write enables. Lane 0 is written by every access size; lane 1 by
    // halfword and word; lanes 2 and 3 by word (MemSize 2 or 3) only.
    // ------------------------------------------------------------------------
    logic w_wrLane1;
    logic w_wrLane23;

    assign w_wrLane1  = (MemSize != c_sizeByte);
    assign w_wrLane23 = MemSize[1];

    // ------------------------------------------------------------------------
    // Array update. Reset takes priority over a simultaneous write so that
    // the array always comes out of reset fully cleared.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: 8'h00};
        end else if (WE) begin
            r_mem[w_laneAddr[0]] <= WD[7:0];
            if (w_wrLane1) begin
                r_mem[w_laneAddr[1]] <= WD[15:8];
            end
            if (w_wrLane23) begin
                r_mem[w_laneAddr[2]] <= WD[23:16];
                r_mem[w_laneAddr[3]] <= WD[31:24];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path. The word is assembled little-endian from the four lanes and
    // then trimmed/extended to the access size. The fill bit is the access's
    // top data bit gated by MemSigned, so zero-extension falls out of the
    // same expression.
    // ------------------------------------------------------------------------
    logic [31:0] w_word;
    logic        w_byteFill;
    logic        w_halfFill;

    assign w_word     = {w_laneByte[3], w_laneByte[2], w_laneByte[1], w_laneByte[0]};
    assign w_byteFill = MemSigned & w_word[7];
    assign w_halfFill = MemSigned & w_word[15];

    always_comb begin
        RD = w_word;
        case (MemSize)
            c_sizeByte: RD = {{24{w_byteFill}}, w_word[7:0]};
            c_sizeHalf: RD = {{16{w_halfFill}}, w_word[15:0]};
            default:    RD = w_word;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory
//  Description : Self-checking bench for memory. Directed accesses cover the
//                little-endian layout, unaligned and wrapping accesses, sign
//                and zero extension, read-during-write and reset; randomised
//                traffic is compared against a byte-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory;

    localparam int c_addrWidth = 13;
    localparam int c_depth     = 2 ** c_addrWidth;

    logic                   clk;
    logic                   rst;
    logic                   WE;
    logic [1:0]             MemSize;
    logic                   MemSigned;
    logic [c_addrWidth-1:0] A;
    logic [31:0]            WD;
    logic [31:0]            RD;

    memory #(.ADDR_WIDTH(c_addrWidth)) dut (
        .clk       (clk),
        .rst       (rst),
        .WE        (WE),
        .MemSize   (MemSize),
        .MemSigned (MemSigned),
        .A         (A),
        .WD        (WD),
        .RD        (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errCount;
    int checkCount;

    // Reference model: plain byte array indexed modulo capacity.
    logic [7:0] model [0:c_depth-1];

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int accessBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] modelRead(input int a, input logic [1:0] sz, input logic sgn);
        logic [31:0] v;
        int          n;
        n = accessBytes(sz);
        v = 32'h0;
        for (int k = 0; k < n; k++) begin
            v = v | (32'(model[(a + k) % c_depth]) << (8 * k));
        end
        // Extend from the top data bit when a signed narrow read is requested.
        if (sgn && n < 4 && v[8 * n - 1]) begin
            v = v | (32'hFFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < c_depth; i++) model[i] = 8'h00;
    endtask

    task automatic doWrite(input int a, input logic [1:0] sz, input logic [31:0] d);
        @(negedge clk);
        A       = c_addrWidth'(a);
        MemSize = sz;
        WD      = d;
        WE      = 1'b1;
        @(posedge clk);
        for (int k = 0; k < accessBytes(sz); k++) begin
            model[(a + k) % c_depth] = d[8 * k +: 8];
        end
        #1;
        WE = 1'b0;
    endtask

    task automatic doRead(input string tag, input int a, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] exp);
        @(negedge clk);
        WE        = 1'b0;
        A         = c_addrWidth'(a);
        MemSize   = sz;
        MemSigned = sgn;
        #1;
        checkValue(tag, RD, exp);
    endtask

    initial begin
        int          a;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] d;

        errCount   = 0;
        checkCount = 0;
        WE         = 1'b1;
        MemSize    = 2'd2;
        MemSigned  = 1'b0;
        A          = '0;
        WD         = 32'hFFFF_FFFF;
        rst        = 1'b1;
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        WE  = 1'b0;

        // Reset state, including the address that was being written.
        doRead("reset_word0",    0,    2'd2, 1'b0, 32'h0);
        doRead("reset_word_top", 8189, 2'd3, 1'b0, 32'h0);
        doRead("reset_word_mid", 4096, 2'd2, 1'b0, 32'h0);

        // Overlapping unaligned word writes.
        doWrite(96, 2'd2, 32'hAABB_CC11);
        doWrite(97, 2'd2, 32'h5544_3322);
        doRead("word96", 96, 2'd2, 1'b0, 32'h4433_2211);
        doRead("word97", 97, 2'd2, 1'b0, 32'h5544_3322);
        doRead("word98", 98, 2'd2, 1'b1, 32'h0055_4433);
        doRead("word99", 99, 2'd3, 1'b0, 32'h0000_5544);
        doRead("byte96", 96, 2'd0, 1'b0, 32'h0000_0011);
        doRead("half96", 96, 2'd1, 1'b0, 32'h0000_2211);
        doRead("byte97", 97, 2'd0, 1'b0, 32'h0000_0022);
        doRead("half97", 97, 2'd1, 1'b0, 32'h0000_3322);

        // Sign / zero extension.
        doWrite(100, 2'd2, 32'h4080_8080);
        doRead("sbyte100", 100, 2'd0, 1'b1, 32'hFFFF_FF80);
        doRead("shalf100", 100, 2'd1, 1'b1, 32'hFFFF_8080);
        doRead("word100",  100, 2'd2, 1'b1, 32'h4080_8080);
        doRead("ubyte100", 100, 2'd0, 1'b0, 32'h0000_0080);
        doRead("uhalf100", 100, 2'd1, 1'b0, 32'h0000_8080);

        // Byte write leaves neighbours untouched.
        doWrite(200, 2'd0, 32'h1234_56AB);
        doRead("byte200", 200, 2'd0, 1'b0, 32'h0000_00AB);
        doRead("word200", 200, 2'd2, 1'b0, 32'h0000_00AB);
        doRead("word201", 201, 2'd2, 1'b0, 32'h0000_0000);

        // Halfword write leaves byte 2 untouched.
        doWrite(300, 2'd2, 32'h1122_3344);
        doWrite(300, 2'd1, 32'hFFFF_BEEF);
        doRead("half_write_span", 300, 2'd2, 1'b0, 32'h1122_BEEF);

        // Wrap at the top of the array.
        doWrite(8190, 2'd2, 32'hDEAD_BEEF);
        doRead("wrap_word0",    0,    2'd2, 1'b0, 32'h0000_DEAD);
        doRead("wrap_word8190", 8190, 2'd2, 1'b0, 32'hDEAD_BEEF);
        doRead("wrap_half8191", 8191, 2'd1, 1'b1, 32'hFFFF_ADBE);

        // Read during write: old contents before the edge, new after.
        @(negedge clk);
        A         = 13'd96;
        MemSize   = 2'd2;
        MemSigned = 1'b0;
        WD        = 32'hCAFE_F00D;
        WE        = 1'b1;
        #1;
        checkValue("rdw_before", RD, 32'h4433_2211);
        @(posedge clk);
        for (int k = 0; k < 4; k++) model[96 + k] = WD[8 * k +: 8];
        #1;
        WE = 1'b0;
        checkValue("rdw_after", RD, 32'hCAFE_F00D);

        // Randomised traffic against the model.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 3) == 0) a = c_depth - 1 - int'($urandom_range(0, 4));
            else                           a = int'($urandom_range(0, 63));
            sz  = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            d   = $urandom;
            if ($urandom_range(0, 1) == 1) doWrite(a, sz, d);
            else                           doRead("random_read", a, sz, sgn, modelRead(a, sz, sgn));
        end

        // Reset with a simultaneous write: everything cleared, write dropped.
        doWrite(500, 2'd2, 32'h0102_0304);
        @(negedge clk);
        rst     = 1'b1;
        WE      = 1'b1;
        A       = 13'd600;
        MemSize = 2'd2;
        WD      = 32'h7777_7777;
        @(posedge clk);
        modelClear();
        #1;
        rst = 1'b0;
        WE  = 1'b0;
        doRead("rst_word500", 500,  2'd2, 1'b0, 32'h0);
        doRead("rst_word600", 600,  2'd2, 1'b0, 32'h0);
        doRead("rst_word96",  96,   2'd2, 1'b0, 32'h0);
        doRead("rst_wrap",    8190, 2'd2, 1'b1, 32'h0);
        for (int it = 0; it < 20; it++) begin
            a = int'($urandom_range(0, c_depth - 1));
            doRead("rst_random", a, 2'd2, 1'b0, modelRead(a, 2'd2, 1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The module SHALL have one parameter, ADDR_WIDTH, default 13, giving the byte-address width; capacity is 2**ADDR_WIDTH bytes.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port WE, input, 1 bit: write enable, sampled at the rising edge of clk.
REQ-005 Port MemSize, input, 2 bits: access size; 0 = byte, 1 = halfword, 2 = word, 3 = word.
REQ-006 Port MemSigned, input, 1 bit: for reads, 1 = sign-extend, 0 = zero-extend byte/halfword data.
REQ-007 Port A, input, ADDR_WIDTH bits: byte address of the access, any alignment.
REQ-008 Port WD, input, 32 bits: write data; the least-significant bytes are used for byte/halfword writes.
REQ-009 Port RD, output, 32 bits: read data.

Function
REQ-010 Storage SHALL be a byte array; multi-byte accesses SHALL be little-endian (byte at A = bits 7:0).
REQ-011 Unaligned halfword and word accesses SHALL be supported with no alignment restriction and no exception signalling.
REQ-012 Byte addresses A+1..A+3 SHALL wrap modulo 2**ADDR_WIDTH.
REQ-013 When WE=1 at a rising clk edge with rst=0, the module SHALL write 1, 2 or 4 bytes of WD (per MemSize) to A..A+n-1.
REQ-014 Bytes outside the written span SHALL be left unchanged.
REQ-015 Reads SHALL be combinational from A, MemSize, MemSigned and the array contents, with zero-cycle latency.
REQ-016 RD SHALL be valid regardless of WE.
REQ-017 Byte read: RD[7:0] = mem[A]; RD[31:8] SHALL be replicated from bit 7 when MemSigned=1, else zero.
REQ-018 Halfword read: RD[15:0] = {mem[A+1], mem[A]}; RD[31:16] SHALL be sign-extended or zero-extended per MemSigned.
REQ-019 Word read (MemSize 2 or 3): RD = {mem[A+3], mem[A+2], mem[A+1], mem[A]}; MemSigned SHALL be ignored.
REQ-020 Read during write: before the edge, RD SHALL show the old contents; after the edge, RD SHALL show the new contents.

Reset
REQ-021 When rst=1 at a rising clk edge, every byte SHALL be cleared to 0x00.
REQ-022 When rst=1, any simultaneous write SHALL be ignored.
REQ-023 After reset, a read of any address SHALL return 0x00000000.
REQ-024 The module SHALL have no output registers; RD is not separately reset.

Verification
REQ-025 Reset, then word-write 0xAABBCC11 at 96, then word-write 0x55443322 at 97 -> word reads return 0x44332211 at 96, 0x55443322 at 97, 0x00554433 at 98 and 0x00005544 at 99.
REQ-026 Same contents, MemSigned=0 -> A=96 byte reads 0x00000011 and halfword reads 0x00002211; A=97 byte reads 0x00000022 and halfword reads 0x00003322.
REQ-027 Word-write 0x40808080 at 100 -> at A=100: signed byte reads 0xFFFFFF80; signed halfword reads 0xFFFF8080; word reads 0x40808080; unsigned byte reads 0x00000080.
REQ-028 Byte-write WD=0x123456AB at 200 with MemSize=0 -> mem[200]=0xAB; bytes 201-203 remain 0x00; word read at 200 returns 0x000000AB.
REQ-029 Word-write 0xDEADBEEF at 8190 (ADDR_WIDTH=13) -> bytes wrap to addresses 8190, 8191, 0 and 1; word read at 0 returns 0x0000DEAD.
REQ-030 Write memory, then hold rst=1 for one edge with WE=1 -> all reads return 0x00000000 and the write data is not stored.
